// File: rtl/audio_serial_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : audio_serial_tx_if
//  Description : Peripheral bus bundle for audio_serial_tx.
//                4-bit address, 16-bit write/read data, block select and
//                read/write strobes. The master drives the strobes, address
//                and write data. The slave returns combinational read data.
//  Revision    : 1.0 - initial release
// ============================================================================
interface audio_serial_tx_if;
    logic [3:0]  Addr;
    logic [15:0] DataWr;
    logic [15:0] DataRd;
    logic        En;
    logic        Rd;
    logic        Wr;

    modport master (output Addr, output DataWr, output En, output Rd, output Wr,
                    input  DataRd);
    modport slave  (input  Addr, input  DataWr, input  En, input  Rd, input  Wr,
                    output DataRd);
endinterface
`default_nettype wire

// File: rtl/audio_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : audio_serial_tx
//  Description : Left-justified serial audio transmitter, 32 bit slots per
//                channel. Stereo 16-bit pairs are written over the peripheral
//                bus into a small FIFO. Each frame pops one pair and shifts it
//                out MSB first. Sdata changes on BitClk falling edges. Lrck is
//                0 for the left channel and 1 for the right channel.
//  Ports       : Clk, Reset   - system clock, synchronous active-high reset
//                bus (slave)  - Addr/DataWr/DataRd/En/Rd/Wr register bus
//                BitClk       - serial bit clock, 2*CLK_DIV Clk per bit
//                Lrck         - frame sync, 0 = left, 1 = right
//                Sdata        - serial data, MSB first
//                FifoEmpty    - FIFO holds no stereo pairs
//  Registers   : 0 LeftHold (R/W)
//                1 RightHold (R/W); a write also pushes {LeftHold, DataWr}
//                2 bit0 Enable
//                3 status {Busy,5'b0,Overflow,Underrun,4'b0,Level[3:0]};
//                  write 1 to bit8 or bit9 to clear that flag
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_serial_tx #(
    parameter int CLK_DIV = 4,
    parameter int FIFO_AW = 3
) (
    input  logic                Clk,
    input  logic                Reset,
    audio_serial_tx_if.slave    bus,
    output logic                BitClk,
    output logic                Lrck,
    output logic                Sdata,
    output logic                FifoEmpty
);

    localparam int c_DEPTH = 1 << FIFO_AW;
    localparam int c_LVL_W = FIFO_AW + 1;
    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_LVL_W-1:0] c_LVL_FULL = c_LVL_W'(c_DEPTH);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [1:0]          w_stateNext;

    logic [15:0]         r_leftHold;
    logic [15:0]         r_rightHold;
    logic                r_enable;
    logic                r_overflow;
    logic                r_underrun;

    logic [31:0]         r_mem [c_DEPTH];
    logic [FIFO_AW-1:0]  r_wrPtr;
    logic [FIFO_AW-1:0]  r_rdPtr;
    logic [c_LVL_W-1:0]  r_level;

    logic [c_DIV_W-1:0]  r_div;
    logic [5:0]          r_bitIdx;
    logic [15:0]         r_frameL;
    logic [15:0]         r_frameR;
    logic                r_bitClk;
    logic                r_lrck;
    logic                r_sdata;

    logic                w_wrEn;
    logic                w_push;
    logic                w_pushOk;
    logic                w_popDo;
    logic                w_full;
    logic                w_empty;
    logic [31:0]         w_popData;
    logic [15:0]         w_loadL;
    logic [15:0]         w_loadR;

    logic                w_tick;
    logic                w_frameEnd;
    logic                w_load;
    logic                w_stop;

    logic [5:0]          w_nextIdx;
    logic [15:0]         w_nextWord;
    logic                w_nextBit;
    logic [3:0]          w_levelField;
    logic [15:0]         w_rdMux;

    // ------------------------------------------------------------------
    // Bus decode and FIFO control
    // ------------------------------------------------------------------
    assign w_wrEn    = bus.En & bus.Wr;
    assign w_push    = w_wrEn && (bus.Addr == 4'd1);
    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == c_LVL_FULL);
    // A pop request on an empty FIFO pops nothing. The frame is loaded
    // with zeros instead.
    assign w_popDo   = w_load & ~w_empty;
    // A full FIFO still accepts a push when a pop frees a slot this cycle.
    assign w_pushOk  = w_push & (~w_full | w_popDo);
    assign w_popData = r_mem[r_rdPtr];
    assign w_loadL   = w_popDo ? w_popData[31:16] : 16'h0000;
    assign w_loadR   = w_popDo ? w_popData[15:0]  : 16'h0000;

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_leftHold  <= 16'h0000;
            r_rightHold <= 16'h0000;
            r_enable    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            if (w_wrEn) begin
                case (bus.Addr)
                    4'd0: r_leftHold  <= bus.DataWr;
                    4'd1: r_rightHold <= bus.DataWr;
                    4'd2: r_enable    <= bus.DataWr[0];
                    4'd3: begin
                        if (bus.DataWr[8]) r_underrun <= 1'b0;
                        if (bus.DataWr[9]) r_overflow <= 1'b0;
                    end
                    default: ;
                endcase
            end
            // The set terms come after the clears, so a set wins.
            if (w_push & ~w_pushOk)
                r_overflow <= 1'b1;
            if (w_load & w_empty)
                r_underrun <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage. The contents need no reset because a slot is only
    // read after it has been written.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (w_pushOk)
            r_mem[r_wrPtr] <= {r_leftHold, bus.DataWr};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_pushOk)
                r_wrPtr <= r_wrPtr + FIFO_AW'(1);
            if (w_popDo)
                r_rdPtr <= r_rdPtr + FIFO_AW'(1);
            case ({w_pushOk, w_popDo})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset)
            r_state <= c_ST_IDLE;
        else
            r_state <= w_stateNext;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_ST_IDLE: if (r_enable) w_stateNext = c_ST_LOAD;
            c_ST_LOAD: w_stateNext = c_ST_RUN;
            c_ST_RUN:  if (w_stop)   w_stateNext = c_ST_IDLE;
            default:   w_stateNext = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_tick     = 1'b0;
        w_frameEnd = 1'b0;
        w_load     = 1'b0;
        w_stop     = 1'b0;
        case (r_state)
            c_ST_LOAD: w_load = 1'b1;
            c_ST_RUN: begin
                w_tick = (r_div == c_DIV_LAST);
                // The frame ends on the falling BitClk edge that leaves
                // bit 63. Enable is checked only here, so a frame is
                // never truncated.
                w_frameEnd = w_tick & r_bitClk & (r_bitIdx == 6'd63);
                w_load     = w_frameEnd & r_enable;
                w_stop     = w_frameEnd & ~r_enable;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Serial datapath
    // ------------------------------------------------------------------
    assign w_nextIdx  = r_bitIdx + 6'd1;
    assign w_nextWord = w_nextIdx[5] ? r_frameR : r_frameL;
    // Slot positions 0..15 carry data MSB first; 15 - n == ~n for 4 bits.
    // Positions 16..31 of each channel are zero.
    assign w_nextBit  = ~w_nextIdx[4] & w_nextWord[~w_nextIdx[3:0]];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_div    <= '0;
            r_bitIdx <= 6'd0;
            r_frameL <= 16'h0000;
            r_frameR <= 16'h0000;
            r_bitClk <= 1'b0;
            r_lrck   <= 1'b0;
            r_sdata  <= 1'b0;
        end else if (w_load) begin
            r_frameL <= w_loadL;
            r_frameR <= w_loadR;
            r_sdata  <= w_loadL[15];
            r_lrck   <= 1'b0;
            r_bitIdx <= 6'd0;
            r_div    <= '0;
            r_bitClk <= 1'b0;
        end else if (r_state == c_ST_RUN) begin
            if (w_tick) begin
                r_div <= '0;
                if (w_stop) begin
                    r_bitClk <= 1'b0;
                    r_lrck   <= 1'b0;
                    r_sdata  <= 1'b0;
                    r_bitIdx <= 6'd0;
                end else if (r_bitClk) begin
                    r_bitClk <= 1'b0;
                    r_bitIdx <= w_nextIdx;
                    r_lrck   <= w_nextIdx[5];
                    r_sdata  <= w_nextBit;
                end else begin
                    r_bitClk <= 1'b1;
                end
            end else begin
                r_div <= r_div + c_DIV_W'(1);
            end
        end else begin
            r_div    <= '0;
            r_bitIdx <= 6'd0;
            r_bitClk <= 1'b0;
            r_lrck   <= 1'b0;
            r_sdata  <= 1'b0;
        end
    end

    assign BitClk    = r_bitClk;
    assign Lrck      = r_lrck;
    assign Sdata     = r_sdata;
    assign FifoEmpty = w_empty;

    // ------------------------------------------------------------------
    // Read mux. Rd only qualifies the output, so reads have no side effects.
    // ------------------------------------------------------------------
    assign w_levelField = 4'(r_level);

    always_comb begin
        w_rdMux = 16'h0000;
        case (bus.Addr)
            4'd0: w_rdMux = r_leftHold;
            4'd1: w_rdMux = r_rightHold;
            4'd2: w_rdMux = {15'h0000, r_enable};
            4'd3: w_rdMux = {(r_state != c_ST_IDLE), 5'b00000, r_overflow,
                             r_underrun, 4'b0000, w_levelField};
            default: w_rdMux = 16'h0000;
        endcase
    end

    assign bus.DataRd = (bus.En & bus.Rd) ? w_rdMux : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_audio_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_serial_tx
//  Description : Directed bench for audio_serial_tx (CLK_DIV=2, FIFO_AW=2).
//                Captures Lrck/Sdata on each BitClk rise and compares each
//                frame against hand-written expected words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_serial_tx;

    logic Clk;
    logic Reset;
    logic BitClk;
    logic Lrck;
    logic Sdata;
    logic FifoEmpty;

    int nCompared;
    int nMismatched;

    audio_serial_tx_if bus ();

    audio_serial_tx #(
        .CLK_DIV (2),
        .FIFO_AW (2)
    ) u_dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .bus       (bus),
        .BitClk    (BitClk),
        .Lrck      (Lrck),
        .Sdata     (Sdata),
        .FifoEmpty (FifoEmpty)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic checkValue(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic busWrite(input logic [3:0] a, input logic [15:0] d);
        bus.Addr   = a;
        bus.DataWr = d;
        bus.En     = 1'b1;
        bus.Wr     = 1'b1;
        @(posedge Clk);
        #1;
        bus.En = 1'b0;
        bus.Wr = 1'b0;
    endtask

    task automatic busRead(input logic [3:0] a, output logic [15:0] d);
        bus.Addr = a;
        bus.En   = 1'b1;
        bus.Rd   = 1'b1;
        #1;
        d = bus.DataRd;
        bus.En = 1'b0;
        bus.Rd = 1'b0;
    endtask

    task automatic checkReg(input string tag, input logic [3:0] a,
                            input logic [15:0] exp);
        logic [15:0] d;
        busRead(a, d);
        checkValue(tag, {48'h0, d}, {48'h0, exp});
    endtask

    // Returns at the first falling Clk edge that sees BitClk high after low.
    task automatic waitRise(output bit ok);
        logic prev;
        prev = BitClk;
        ok   = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge Clk);
            if (BitClk && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = BitClk;
        end
        if (!ok) checkValue("bitclk_rise_timeout", 64'd0, 64'd1);
    endtask

    // Collects one 64-bit frame (first bit ends up in bit 63). Optional hooks:
    // clear Enable after rise stopAt, push a pair after rise pushAt, and push
    // a right word on the same Clk edge as the end-of-frame reload.
    task automatic captureFrame(input int stopAt, input int pushAt,
                                input logic [15:0] pushL, input logic [15:0] pushR,
                                input bit endPush, input logic [15:0] endR,
                                output logic [63:0] dat, output logic [63:0] lr);
        bit ok;
        dat = '0;
        lr  = '0;
        for (int i = 0; i < 64; i++) begin
            waitRise(ok);
            if (!ok) break;
            dat = {dat[62:0], Sdata};
            lr  = {lr[62:0], Lrck};
            if (i == stopAt) busWrite(4'd2, 16'h0000);
            if (i == pushAt) begin
                busWrite(4'd0, pushL);
                busWrite(4'd1, pushR);
            end
            if (i == 63 && endPush) begin
                @(negedge Clk);
                busWrite(4'd1, endR);
            end
        end
    endtask

    task automatic waitIdle();
        logic [15:0] s;
        bit done;
        done = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge Clk);
            busRead(4'd3, s);
            if (!s[15]) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) checkValue("idle_timeout", 64'd0, 64'd1);
    endtask

    localparam logic [63:0] c_LR = 64'h0000_0000_FFFF_FFFF;

    logic [63:0] dat;
    logic [63:0] lr;
    logic [15:0] cL [4];
    logic [15:0] cR [4];
    bit ok;

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        bus.Addr    = 4'd0;
        bus.DataWr  = 16'h0000;
        bus.En      = 1'b0;
        bus.Rd      = 1'b0;
        bus.Wr      = 1'b0;
        Reset       = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);

        // Reset state
        checkValue("rst_bitclk", {63'd0, BitClk}, 64'd0);
        checkValue("rst_lrck", {63'd0, Lrck}, 64'd0);
        checkValue("rst_sdata", {63'd0, Sdata}, 64'd0);
        checkValue("rst_fifoempty", {63'd0, FifoEmpty}, 64'd1);
        checkReg("rst_status", 4'd3, 16'h0000);

        // Single frame, Enable cleared at BitIdx 20
        busWrite(4'd0, 16'h8001);
        busWrite(4'd1, 16'h7FFE);
        checkReg("rd_left", 4'd0, 16'h8001);
        checkReg("rd_right", 4'd1, 16'h7FFE);
        checkReg("level1", 4'd3, 16'h0001);
        busWrite(4'd4, 16'hFFFF);
        checkReg("rd_addr4", 4'd4, 16'h0000);
        busWrite(4'd2, 16'h0001);
        captureFrame(20, -1, 16'h0, 16'h0, 1'b0, 16'h0, dat, lr);
        checkValue("frameA_data", dat, 64'h8001_0000_7FFE_0000);
        checkValue("frameA_lrck", lr, c_LR);
        waitIdle();
        checkValue("stop_bitclk", {63'd0, BitClk}, 64'd0);
        checkValue("stop_lrck", {63'd0, Lrck}, 64'd0);
        checkValue("stop_sdata", {63'd0, Sdata}, 64'd0);
        checkReg("stop_status", 4'd3, 16'h0000);
        checkReg("stop_enable", 4'd2, 16'h0000);

        // Underrun with an empty FIFO
        busWrite(4'd2, 16'h0001);
        captureFrame(10, -1, 16'h0, 16'h0, 1'b0, 16'h0, dat, lr);
        checkValue("underrun_data", dat, 64'h0);
        checkValue("underrun_lrck", lr, c_LR);
        waitIdle();
        checkReg("underrun_flag", 4'd3, 16'h0100);
        busWrite(4'd3, 16'h0100);
        checkReg("underrun_clr", 4'd3, 16'h0000);

        // Overflow: five pairs into a four-deep FIFO
        cL[0] = 16'h1111; cR[0] = 16'hA001;
        cL[1] = 16'h2222; cR[1] = 16'hA002;
        cL[2] = 16'h3333; cR[2] = 16'hA003;
        cL[3] = 16'h4444; cR[3] = 16'hA004;
        for (int k = 0; k < 4; k++) begin
            busWrite(4'd0, cL[k]);
            busWrite(4'd1, cR[k]);
        end
        busWrite(4'd0, 16'h5555);
        busWrite(4'd1, 16'hA005);
        checkReg("overflow_status", 4'd3, 16'h0204);
        checkValue("overflow_notempty", {63'd0, FifoEmpty}, 64'd0);
        busWrite(4'd3, 16'h0200);
        checkReg("overflow_clr", 4'd3, 16'h0004);
        busWrite(4'd2, 16'h0001);
        for (int k = 0; k < 4; k++) begin
            captureFrame(-1, -1, 16'h0, 16'h0, 1'b0, 16'h0, dat, lr);
            checkValue($sformatf("order_data%0d", k), dat,
                       {cL[k], 16'h0000, cR[k], 16'h0000});
            checkValue($sformatf("order_lrck%0d", k), lr, c_LR);
        end
        captureFrame(5, -1, 16'h0, 16'h0, 1'b0, 16'h0, dat, lr);
        checkValue("drained_data", dat, 64'h0);
        waitIdle();
        checkReg("drained_status", 4'd3, 16'h0100);
        busWrite(4'd3, 16'h0100);

        // Push on the reload cycle while full
        for (int k = 0; k < 4; k++) begin
            busWrite(4'd0, 16'hC000 + 16'(k));
            busWrite(4'd1, 16'hD000 + 16'(k));
        end
        checkReg("full_status", 4'd3, 16'h0004);
        busWrite(4'd2, 16'h0001);
        captureFrame(-1, 10, 16'hE000, 16'hE001, 1'b1, 16'hF001, dat, lr);
        checkValue("full_frame_data", dat, 64'hC000_0000_D000_0000);
        checkReg("push_on_pop_status", 4'd3, 16'h8004);
        checkReg("push_on_pop_right", 4'd1, 16'hF001);
        checkReg("run_enable", 4'd2, 16'h0001);

        // Reset at BitIdx 40
        for (int i = 0; i <= 40; i++) begin
            waitRise(ok);
            if (!ok) break;
        end
        checkValue("bit40_lrck", {63'd0, Lrck}, 64'd1);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        checkValue("midrst_bitclk", {63'd0, BitClk}, 64'd0);
        checkValue("midrst_lrck", {63'd0, Lrck}, 64'd0);
        checkValue("midrst_sdata", {63'd0, Sdata}, 64'd0);
        checkValue("midrst_fifoempty", {63'd0, FifoEmpty}, 64'd1);
        checkReg("midrst_status", 4'd3, 16'h0000);
        checkReg("midrst_enable", 4'd2, 16'h0000);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_serial_tx.md
Name: audio_serial_tx

Overview:
- Serial audio transmitter: the sending end of the left-justified, 32-bit-per-channel link that our PWM DAC block receives.
- Generates bit clock, frame sync (LRCK) and MSB-first serial data from stereo 16-bit samples.
- Samples are written over the standard 4-bit-address peripheral bus and buffered in a small stereo FIFO.
- Used to loop generated audio into the DAC path and to drive external codecs.

Parameters:
- CLK_DIV, 4: Clk cycles per BitClk half-period, minimum 1.
- FIFO_AW, 3: log2 FIFO depth, in stereo pairs.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Addr  in  4  register address.
- DataWr  in  16  write data.
- DataRd  out  16  read data, combinational.
- En  in  1  block select.
- Rd  in  1  read strobe, decode only; no read side effects.
- Wr  in  1  write strobe; a write occurs on a Clk edge with En&Wr.
- BitClk  out  1  serial bit clock.
- Lrck  out  1  frame sync; 0 = left, 1 = right.
- Sdata  out  1  serial data; changes only with BitClk falling.
- FifoEmpty  out  1  FIFO holds no pairs.

Behaviour:
- Reset: all registers, FIFO pointers and outputs 0; FifoEmpty=1; state IDLE.
- Register map:
  - Addr 0: LeftHold, R/W.
  - Addr 1: a write sets RightHold and pushes {LeftHold, DataWr}; reads return RightHold.
  - Addr 2: bit0 Enable, R/W; other bits read 0.
  - Addr 3: status, read {Busy[15], 5'b0, Overflow[9], Underrun[8], 4'b0, Level[3:0]}. Level is zero-extended count of pairs; Busy = (state != IDLE). Writing 1 to bit8 or bit9 clears that flag.
  - Addr 4-15: DataRd = 0; writes ignored.
- Push accepted if not full, or if a pop occurs the same cycle. Otherwise the pair is dropped and Overflow is set.
- Flag set and clear in the same cycle: set wins.
- FIFO pointers wrap modulo 2^FIFO_AW; Level range 0..2^FIFO_AW.
- States:
  - IDLE: BitClk=Lrck=Sdata=0, divider=0, BitIdx=0. If Enable, go to LOAD.
  - LOAD (1 cycle): pop one pair into frame register L/R. If FIFO empty, load 0/0 and set Underrun. Set Sdata=L[15], Lrck=0, BitIdx=0, divider=0. Go to RUN.
  - RUN: divider counts 0..CLK_DIV-1; at terminal count it resets and BitClk toggles.
    - BitClk 0->1 (rising): no data change; the receiver samples here.
    - BitClk 1->0 (falling), BitIdx<63: BitIdx+1. Set Lrck=BitIdx_new[5]. Sdata = bit (15 - BitIdx_new[4:0]) of L (Lrck=0) or R (Lrck=1) when BitIdx_new[4:0]<16, else 0.
    - BitClk 1->0 (falling), BitIdx=63: if Enable, reload as in LOAD (pop or underrun) in that same cycle and stay in RUN; else go to IDLE with outputs 0.
- Clearing Enable mid-frame: the current frame completes, then stop. No truncated frames.
- Timing:
  - Bit period 2*CLK_DIV cycles; frame 64 bits = 128*CLK_DIV cycles.
  - First BitClk rise is CLK_DIV cycles after LOAD.
  - Lrck and MSB change together on the falling edge that starts each channel.
- Push and pop same cycle on an empty FIFO: the pop sees empty (underrun, zeros); the push is accepted.
- Bus writes do not affect the frame already loaded.
- Reset mid-frame aborts immediately to reset values.

Test Plan:
- CLK_DIV=2, FIFO_AW=2. Write L=0x8001, R=0x7FFE, Enable=1 -> BitClk period 4 cycles. First rise 2 cycles after LOAD. Sampled on rising edges: Lrck=0 for 32 bits with data 1000000000000001 + 16 zeros. Then Lrck=1 for 32 bits with 0111111111111110 + 16 zeros.
- Enable with empty FIFO -> zeros transmitted, Underrun=1, status read bit8=1. Write 0x0100 to addr 3 -> bit8=0.
- Write 5 pairs with Enable=0 -> Level=4, Overflow=1, 5th pair dropped. Enable -> the 4 frames come out in write order, then an underrun frame.
- Push on the same cycle as the BitIdx=63 reload pop while full -> push accepted, Level stays 4, Overflow stays 0.
- Clear Enable at BitIdx=20 -> frame runs to BitIdx 63, then IDLE, BitClk/Lrck/Sdata=0, Busy=0.
- Assert Reset at BitIdx=40 -> next cycle all outputs 0, Level=0, FifoEmpty=1, Enable=0.
